mem_ext_req_adapter: RTL and testbench

MEM_EXT_REQ_ADAPTER -- requirements
Module: mem_ext_req_adapter

---
 rtl/mem_ext_req_adapter.sv | 121 ++++++++++++
 tb/tb_mem_ext_req_adapter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ext_req_adapter.sv
// Request/response adapter in front of a 1R1W synchronous memory: issues reads/writes,
// tracks one in-flight read beat and buffers responses in a 3-entry in-order queue.
// Optional macro MEM_EXT_ADAPTER_WRITE_ACK_EN makes every accepted write return an ack beat.
module mem_ext_req_adapter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [12:0] req_addr,
  input  logic        req_write,
  input  logic [63:0] req_data,
  input  logic [7:0]  req_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_write,
  output logic [12:0] mem_R0_addr,
  output logic        mem_R0_en,
  input  logic [63:0] mem_R0_data,
  output logic [12:0] mem_W0_addr,
  output logic        mem_W0_en,
  output logic [63:0] mem_W0_data,
  output logic [7:0]  mem_W0_mask
);

`ifdef MEM_EXT_ADAPTER_WRITE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  localparam int DEPTH = 3;

  logic        infl_valid_q, infl_valid_d;
  logic        infl_write_q, infl_write_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [63:0] q_data_q  [DEPTH];
  logic [63:0] q_data_d  [DEPTH];
  logic        q_write_q [DEPTH];
  logic        q_write_d [DEPTH];

  logic [2:0]  occupancy;
  logic        accept;
  logic        push;
  logic        pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every signal assigned in this block gets its default first, so no latch can be inferred.
  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, infl_valid_q};
    // Credit check uses registered state only, so resp_ready never reaches req_ready.
    req_ready = (occupancy < 3'd3);
    accept    = req_valid && req_ready && !reset;

    mem_R0_addr = req_addr;
    mem_W0_addr = req_addr;
    mem_W0_data = req_data;
    mem_W0_mask = req_mask;
    mem_R0_en   = accept && !req_write;
    mem_W0_en   = accept && req_write;

    resp_valid = (count_q != 2'd0) && !reset;
    resp_data  = resp_valid ? q_data_q[rd_ptr_q] : 64'd0;
    resp_write = ACK_EN && resp_valid && q_write_q[rd_ptr_q];

    push = infl_valid_q;
    pop  = resp_valid && resp_ready;

    infl_valid_d = accept && (!req_write || ACK_EN);
    infl_write_d = accept && req_write && ACK_EN;

    q_data_d  = q_data_q;
    q_write_d = q_write_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push) begin
      q_data_d[wr_ptr_q]  = infl_write_q ? 64'd0 : mem_R0_data;
      q_write_d[wr_ptr_q] = infl_write_q;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clock) begin
    if (reset) begin
      infl_valid_q <= 1'b0;
      infl_write_q <= 1'b0;
      count_q      <= 2'd0;
      rd_ptr_q     <= 2'd0;
      wr_ptr_q     <= 2'd0;
    end else begin
      infl_valid_q <= infl_valid_d;
      infl_write_q <= infl_write_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // NOTE: queue storage is not reset; entries are only visible through resp_valid, which reset clears.
  always_ff @(posedge clock) begin
    q_data_q  <= q_data_d;
    q_write_q <= q_write_d;
  end

endmodule

// File: tb/tb_mem_ext_req_adapter.sv
// Directed self-checking bench for mem_ext_req_adapter with a behavioural 1R1W memory.
// Expectations follow MEM_EXT_ADAPTER_WRITE_ACK_EN when the bench is built with it.
module tb_mem_ext_req_adapter;

`ifdef MEM_EXT_ADAPTER_WRITE_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_addr;
  logic        req_write;
  logic [63:0] req_data;
  logic [7:0]  req_mask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_write;
  logic [12:0] mem_R0_addr;
  logic        mem_R0_en;
  logic [63:0] mem_R0_data;
  logic [12:0] mem_W0_addr;
  logic        mem_W0_en;
  logic [63:0] mem_W0_data;
  logic [7:0]  mem_W0_mask;

  mem_ext_req_adapter dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_write  (resp_write),
    .mem_R0_addr (mem_R0_addr),
    .mem_R0_en   (mem_R0_en),
    .mem_R0_data (mem_R0_data),
    .mem_W0_addr (mem_W0_addr),
    .mem_W0_en   (mem_W0_en),
    .mem_W0_data (mem_W0_data),
    .mem_W0_mask (mem_W0_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory: masked write, read data one cycle after the enable.
  logic [63:0] mem [8192];
  always @(posedge clock) begin
    if (mem_W0_en) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_W0_mask[b]) mem[mem_W0_addr][8*b +: 8] <= mem_W0_data[8*b +: 8];
      end
    end
    if (mem_R0_en) mem_R0_data <= mem[mem_R0_addr];
  end

  int unsigned cyc;
  always @(posedge clock) cyc <= cyc + 1;

  // Response monitor, sampled mid-cycle.
  logic [63:0] rd_q [$];
  int unsigned rd_cyc_q [$];
  int          ack_cnt;
  logic [63:0] ack_or;
  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      if (resp_write) begin
        ack_cnt = ack_cnt + 1;
        ack_or  = ack_or | resp_data;
      end else begin
        rd_q.push_back(resp_data);
        rd_cyc_q.push_back(cyc);
      end
    end
  end

  int total;
  int bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic issue(input logic w, input logic [12:0] a, input logic [63:0] d, input logic [7:0] m);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    tick();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  int          acc;
  int          unstable;
  int          not_rdy;
  logic        have_ref;
  logic [63:0] ref_data;

  initial begin
    total = 0; bad = 0; ack_cnt = 0; ack_or = '0; cyc = 0;
    reset = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h5; req_data = '0; req_mask = '0;

    // Reset holds everything quiet even with a request presented.
    repeat (2) tick();
    sample();
    check("rst_r0_en", mem_R0_en, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_write", resp_write, 0);
    req_write = 1'b1;
    #1;
    check("rst_w0_en", mem_W0_en, 0);
    tick();
    reset = 1'b0; req_valid = 1'b0;
    sample();
    check("ready_after_rst", req_ready, 1);

    // Full write then immediate read of the same word; timing of the read beat.
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h0010;
    req_data = 64'h0123456789ABCDEF; req_mask = 8'hFF;
    sample();
    check("wr_w0_en", mem_W0_en, 1);
    check("wr_r0_en", mem_R0_en, 0);
    check("wr_w0_addr", mem_W0_addr, 13'h0010);
    check("wr_w0_data", mem_W0_data, 64'h0123456789ABCDEF);
    check("wr_w0_mask", mem_W0_mask, 8'hFF);
    tick();
    req_write = 1'b0;
    sample();
    check("rd_r0_en", mem_R0_en, 1);
    check("rd_r0_addr", mem_R0_addr, 13'h0010);
    tick();
    req_valid = 1'b0;
    sample();
    check("rd_n1_valid", resp_valid, ACK);
    tick();
    sample();
    check("rd_n2_valid", resp_valid, 1);
    check("rd_n2_write", resp_write, 0);
    check("rd_n2_data", resp_data, 64'h0123456789ABCDEF);
    idle(4);

    // Partial-mask write merges over the old word.
    rd_q.delete();
    issue(1'b1, 13'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    issue(1'b0, 13'h0010, 64'd0, 8'h00);
    idle(4);
    check("merge_cnt", 64'(rd_q.size()), 1);
    check("merge_data", rd_q[0], 64'h01234567FFFFFFFF);

    // Zero-mask write still issues a memory write and changes nothing.
    rd_q.delete();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h0010; req_data = 64'd0; req_mask = 8'h00;
    sample();
    check("zmask_w0_en", mem_W0_en, 1);
    check("zmask_w0_mask", mem_W0_mask, 8'h00);
    tick();
    issue(1'b0, 13'h0010, 64'd0, 8'h00);
    idle(4);
    check("zmask_data", rd_q[0], 64'h01234567FFFFFFFF);

    // Eight back-to-back reads at full throughput.
    for (int i = 0; i < 8; i++) issue(1'b1, 13'(13'h100 + i), pat(i), 8'hFF);
    idle(4);
    rd_q.delete(); rd_cyc_q.delete();
    not_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 13'(13'h100 + i);
      sample();
      if (!req_ready) not_rdy++;
      tick();
    end
    idle(4);
    check("b2b_not_ready", 64'(not_rdy), 0);
    check("b2b_cnt", 64'(rd_q.size()), 8);
    for (int i = 0; i < 8; i++) check($sformatf("b2b_data%0d", i), rd_q[i], pat(i));
    check("b2b_span", 64'(rd_cyc_q[7] - rd_cyc_q[0]), 7);

    // Backpressure: three credits, then stall with a stable head.
    rd_q.delete();
    resp_ready = 1'b0; acc = 0; unstable = 0; have_ref = 1'b0; ref_data = '0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 13'(13'h100 + acc);
      sample();
      if (req_ready) acc++;
      if (resp_valid) begin
        if (!have_ref) begin
          ref_data = resp_data; have_ref = 1'b1;
        end else if (resp_data !== ref_data) begin
          unstable++;
        end
      end
      tick();
    end
    req_valid = 1'b0;
    sample();
    check("bp_accepts", 64'(acc), 3);
    check("bp_ready", req_ready, 0);
    check("bp_valid", resp_valid, 1);
    check("bp_head", resp_data, pat(0));
    check("bp_head_write", resp_write, 0);
    check("bp_unstable", 64'(unstable), 0);
    resp_ready = 1'b1;
    idle(4);
    check("bp_drain_cnt", 64'(rd_q.size()), 3);
    for (int i = 0; i < 3; i++) check($sformatf("bp_drain%0d", i), rd_q[i], pat(i));

    // Reset with two beats queued discards them.
    rd_q.delete();
    resp_ready = 1'b0;
    issue(1'b0, 13'h100, 64'd0, 8'h00);
    issue(1'b0, 13'h101, 64'd0, 8'h00);
    idle(3);
    sample();
    check("mid_pre_valid", resp_valid, 1);
    reset = 1'b1;
    tick();
    sample();
    check("mid_rst_valid", resp_valid, 0);
    tick();
    reset = 1'b0; resp_ready = 1'b1;
    sample();
    check("mid_ready", req_ready, 1);
    idle(4);
    sample();
    check("mid_no_stale", 64'(rd_q.size()), 0);
    check("mid_valid_after", resp_valid, 0);
    issue(1'b0, 13'h0010, 64'd0, 8'h00);
    idle(4);
    check("mid_mem_kept", rd_q[0], 64'h01234567FFFFFFFF);

    // Last word: ack only when acks are enabled; readback matches.
    rd_q.delete(); ack_cnt = 0; ack_or = '0;
    issue(1'b1, 13'h1FFF, 64'hDEADBEEFCAFEF00D, 8'hFF);
    idle(4);
    check("last_ack_cnt", 64'(ack_cnt), 64'(ACK));
    check("last_ack_data", ack_or, 0);
    issue(1'b0, 13'h1FFF, 64'd0, 8'h00);
    idle(4);
    check("last_rd_cnt", 64'(rd_q.size()), 1);
    check("last_rd_data", rd_q[0], 64'hDEADBEEFCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
